mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl
// Brief    : Iterative 32x32 radix-2 multiplier for MUL/MULH/MULHSU/MULHU.
// Revision : 1.0
// ============================================================================
module mul_seq_ctrl #(
    parameter int EARLY_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  tag_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  tag_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHU  = 2'b11;
    localparam logic [5:0] c_LAST_STEP = 6'd31;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic        neg_q;
    logic [1:0]  op_q;
    logic [4:0]  tag_lat_q;
    logic [31:0] result_q;
    logic [4:0]  tag_q;

    logic        accept_d;
    logic        a_signed_d;
    logic        b_signed_d;
    logic [31:0] a_abs_d;
    logic [31:0] b_abs_d;
    logic        neg_d;
    logic        zero_op_d;
    logic [63:0] acc_d;
    logic [63:0] prod_d;
    logic [31:0] slice_d;

    always_comb begin
        accept_d   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !flush_i;
        a_signed_d = (op_i != c_OP_MULHU);
        b_signed_d = (op_i == c_OP_MUL) || (op_i == c_OP_MULH);
        // Negating 0x80000000 in 32 bits yields 0x80000000, read as unsigned magnitude.
        a_abs_d    = (a_signed_d && rs1_i[31]) ? (~rs1_i + 32'd1) : rs1_i;
        b_abs_d    = (b_signed_d && rs2_i[31]) ? (~rs2_i + 32'd1) : rs2_i;
        neg_d      = (a_signed_d && rs1_i[31]) ^ (b_signed_d && rs2_i[31]);
        zero_op_d  = (EARLY_ZERO != 0) && ((rs1_i == 32'd0) || (rs2_i == 32'd0));
        acc_d      = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        prod_d     = neg_q ? (~acc_q + 64'd1) : acc_q;
        slice_d    = (op_q == c_OP_MUL) ? prod_d[31:0] : prod_d[63:32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            neg_q     <= 1'b0;
            op_q      <= 2'b00;
            tag_lat_q <= 5'd0;
            result_q  <= 32'd0;
            tag_q     <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_d) begin
                        op_q      <= op_i;
                        tag_lat_q <= tag_i;
                        neg_q     <= neg_d;
                        mcand_q   <= {32'd0, a_abs_d};
                        mplier_q  <= b_abs_d;
                        cnt_q     <= 6'd0;
                        acc_q     <= 64'd0;
                        if (zero_op_d) begin
                            result_q <= 32'd0;
                            tag_q    <= tag_i;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == c_LAST_STEP) begin
                            state_q <= S_SIGN;
                        end
                    end
                end
                S_SIGN: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= slice_d;
                        tag_q    <= tag_lat_q;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_o   = (state_q == S_CALC) || (state_q == S_SIGN);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Directed self-checking bench for mul_seq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic [4:0]  tag_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  tag_o;

    int errors = 0;
    int checks = 0;

    mul_seq_ctrl #(.EARLY_ZERO(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .tag_i    (tag_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .tag_o    (tag_o)
    );

    always #5 clk = ~clk;

    // Latency counts the acceptance edge as edge 1; returns -1 on timeout.
    task automatic wait_valid(output int lat, output int nbusy);
        bit done = 0;
        lat   = 1;
        nbusy = 0;
        while (!done) begin
            @(negedge clk);
            if (valid_o) begin
                done = 1;
            end else begin
                if (busy_o) nbusy++;
                if (lat >= 100) begin
                    lat  = -1;
                    done = 1;
                end else begin
                    @(posedge clk);
                    lat++;
                end
            end
        end
    endtask

    // Drives a request at a negedge and returns once the result is seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output int lat, output int nbusy);
        op_i = op; rs1_i = a; rs2_i = b; tag_i = tag; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_valid(lat, nbusy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
        checks++; if (tag_o !== 5'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", tag_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        int lat, nb;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, nb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d exp=34", lat); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=33", nb); end
        checks++; if (result_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", result_o); end
        checks++; if (tag_o !== 5'd5) begin errors++; $display("FAIL mul_tag got=%0d exp=5", tag_o); end
        @(negedge clk);
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL mul_valid_one_cycle got valid=%b ready=%b exp valid=0 ready=1", valid_o, ready_o); end
    endtask

    task automatic test_ops();
        logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] bs  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd30};
        int lat, nb;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 10), lat, nb);
            checks++; if (result_o !== exp[i] || lat !== 34) begin errors++; $display("FAIL op_vector%0d got=%h lat=%0d exp=%h lat=34", i, result_o, lat, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_early_zero();
        int lat, nb;
        run_op(2'b00, 32'd1234, 32'd0, 5'd9, lat, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ez_latency got=%0d exp=1", lat); end
        checks++; if (result_o !== 32'd0 || tag_o !== 5'd9) begin errors++; $display("FAIL ez_result got=%h tag=%0d exp=0 tag=9", result_o, tag_o); end
        @(negedge clk);
        run_op(2'b11, 32'd0, 32'hFFFF_FFFF, 5'd8, lat, nb);
        checks++; if (lat !== 1 || result_o !== 32'd0 || tag_o !== 5'd8) begin errors++; $display("FAIL ez_zero_a got lat=%0d res=%h tag=%0d exp lat=1 res=0 tag=8", lat, result_o, tag_o); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int lat, nb;
        op_i = 2'b00; rs1_i = 32'd7; rs2_i = 32'd3; tag_i = 5'd1; start_i = 1'b1;
        @(posedge clk);
        #1 op_i = 2'b11; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'd0; tag_i = 5'd30;
        lat = 1; nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_o) nb++;
            @(posedge clk);
            lat++;
        end
        #1 start_i = 1'b0;
        begin
            int l2, n2;
            wait_valid(l2, n2);
            lat = lat + l2 - 1;
            nb  = nb + n2;
        end
        checks++; if (result_o !== 32'd21 || tag_o !== 5'd1) begin errors++; $display("FAIL busy_start_result got=%h tag=%0d exp=15 tag=1", result_o, tag_o); end
        checks++; if (lat !== 34 || nb !== 33) begin errors++; $display("FAIL busy_start_timing got lat=%0d busy=%0d exp 34/33", lat, nb); end
        @(negedge clk);
    endtask

    task automatic test_flush_calc();
        int lat, nb, seen;
        op_i = 2'b00; rs1_i = 32'd100; rs2_i = 32'd100; tag_i = 5'd12; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle got ready=%b busy=%b exp 1/0", ready_o, busy_o); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
        checks++; if (result_o !== 32'd21 || tag_o !== 5'd1) begin errors++; $display("FAIL flush_retain got=%h tag=%0d exp=15 tag=1", result_o, tag_o); end
        run_op(2'b00, 32'd6, 32'd7, 5'd3, lat, nb);
        checks++; if (result_o !== 32'd42 || tag_o !== 5'd3 || lat !== 34) begin errors++; $display("FAIL flush_next got=%h tag=%0d lat=%0d exp=2a tag=3 lat=34", result_o, tag_o, lat); end
        @(negedge clk);
    endtask

    task automatic test_flush_ready();
        int lat, nb;
        // Flush with start in DONE: result still shown, start refused.
        op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd5; tag_i = 5'd4; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_valid(lat, nb);
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd25) begin errors++; $display("FAIL flush_done_valid got v=%b res=%h exp 1/19", valid_o, result_o); end
        start_i = 1'b1; flush_i = 1'b1; rs1_i = 32'd2; rs2_i = 32'd2; tag_i = 5'd6;
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL flush_done_refuse got r=%b b=%b v=%b exp 1/0/0", ready_o, busy_o, valid_o); end
        // Flush with start in IDLE.
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || tag_o !== 5'd4) begin errors++; $display("FAIL flush_idle_refuse got b=%b v=%b tag=%0d exp 0/0/4", busy_o, valid_o, tag_o); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, seen;
        op_i = 2'b01; rs1_i = 32'h1234_5678; rs2_i = 32'h0FED_CBA9; tag_i = 5'd17; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; flush_i = 1'b1; start_i = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1; flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'd0 || tag_o !== 5'd0)
            begin errors++; $display("FAIL midreset_outputs got r=%b b=%b v=%b res=%h tag=%0d exp 1/0/0/0/0", ready_o, busy_o, valid_o, result_o, tag_o); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_valid got=%0d exp=0", seen); end
        run_op(2'b11, 32'd3, 32'd5, 5'd7, lat, nb);
        checks++; if (result_o !== 32'd0 || tag_o !== 5'd7 || lat !== 34) begin errors++; $display("FAIL midreset_next got=%h tag=%0d lat=%0d exp=0 tag=7 lat=34", result_o, tag_o, lat); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_op(2'b00, 32'd7, 32'd3, 5'd1, lat, nb);
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd21) begin errors++; $display("FAIL b2b_first got v=%b res=%h exp 1/15", valid_o, result_o); end
        op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; tag_i = 5'd2; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_valid(lat, nb);
        checks++; if (lat !== 34 || nb !== 33) begin errors++; $display("FAIL b2b_timing got lat=%0d busy=%0d exp 34/33", lat, nb); end
        checks++; if (result_o !== 32'd81 || tag_o !== 5'd2) begin errors++; $display("FAIL b2b_second got=%h tag=%0d exp=51 tag=2", result_o, tag_o); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_ops();
        test_early_zero();
        test_start_ignored();
        test_flush_calc();
        test_flush_ready();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
